// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_seq_pkg
//  Description : Shared types and constants for the program-counter sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

    localparam int          PC_XLEN         = 32;
    localparam int          INSTR_BYTES     = 4;
    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] PC_TRAP_VECTOR  = 32'h0000_0100;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STALL    = 2'd2,
        ST_REDIRECT = 2'd3
    } state_t;

    // A fetch target is legal only on an instruction boundary.
    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage : pc_seq_pkg
`default_nettype wire

// File: rtl/pc_next_mux.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_mux
//  Description : Priority select of the next fetch address with alignment
//                and stall-timeout trapping. Purely combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_next_mux
    import pc_seq_pkg::*;
#(
    parameter int              XLEN        = PC_XLEN,
    parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(PC_TRAP_VECTOR)
) (
    input  state_t            state_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic [XLEN-1:0]   branch_target_i,
    input  logic              jump_i,
    input  logic [XLEN-1:0]   jump_target_i,
    input  logic              trap_i,
    input  logic              timeout_hit_i,
    output logic [XLEN-1:0]   pc_next_o,
    output logic              redirect_o,
    output logic              misalign_o,
    output logic              timeout_o,
    output logic [XLEN-1:0]   target_o
);

    logic [XLEN-1:0] w_target;

    // Jump outranks branch when both are requested.
    assign w_target = jump_i ? jump_target_i : branch_target_i;
    assign target_o = w_target;

    // Priority: trap > jump > branch > stall > sequential; BOOT holds the PC.
    always_comb begin
        pc_next_o  = pc_i;
        redirect_o = 1'b0;
        misalign_o = 1'b0;
        timeout_o  = 1'b0;
        case (state_i)
            ST_RUN, ST_STALL: begin
                if (trap_i) begin
                    pc_next_o  = TRAP_VECTOR;
                    redirect_o = 1'b1;
                end else if (jump_i || branch_taken_i) begin
                    redirect_o = 1'b1;
                    if (is_aligned(w_target[1:0])) begin
                        pc_next_o = w_target;
                    end else begin
                        pc_next_o  = TRAP_VECTOR;
                        misalign_o = 1'b1;
                    end
                end else if (stall_i) begin
                    // Timeout only counts stall cycles already spent in STALL.
                    if ((state_i == ST_STALL) && timeout_hit_i) begin
                        pc_next_o  = TRAP_VECTOR;
                        timeout_o  = 1'b1;
                        redirect_o = 1'b1;
                    end
                end else begin
                    pc_next_o = pc_i + XLEN'(INSTR_BYTES);
                end
            end
            ST_REDIRECT: begin
                // Only a trap survives the bubble; other requests are flushed.
                if (trap_i) begin
                    pc_next_o  = TRAP_VECTOR;
                    redirect_o = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule : pc_next_mux
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program-counter controller: sequential fetch, redirects with
//                a one-cycle flush bubble, misalign and stall-timeout traps.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              XLEN          = PC_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR  = XLEN'(PC_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR   = XLEN'(PC_TRAP_VECTOR),
    parameter int              STALL_TIMEOUT = 16,
    parameter int              CNT_W         = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic [XLEN-1:0]   branch_target_i,
    input  logic              jump_i,
    input  logic [XLEN-1:0]   jump_target_i,
    input  logic              trap_i,
    output logic [XLEN-1:0]   pc_o,
    output logic [XLEN-1:0]   pc_next_o,
    output logic              pc_valid_o,
    output logic              flush_o,
    output logic              misalign_o,
    output logic              timeout_o,
    output logic [XLEN-1:0]   bad_addr_o,
    output logic [1:0]        state_o
);

    // Count value on which the next stalled cycle fires the timeout.
    localparam logic [CNT_W-1:0] c_STALL_LIMIT =
        (STALL_TIMEOUT == 0) ? '0 : CNT_W'(STALL_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              misalign_q, timeout_q;
    logic [XLEN-1:0]   bad_addr_q, bad_addr_d;

    logic              w_timeout_hit;
    logic              w_redirect;
    logic              w_misalign;
    logic              w_timeout;
    logic [XLEN-1:0]   w_target;

    assign w_timeout_hit = (STALL_TIMEOUT != 0) && (cnt_q == c_STALL_LIMIT);

    pc_next_mux #(
        .XLEN        (XLEN),
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_mux (
        .state_i         (state_q),
        .pc_i            (pc_q),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .trap_i          (trap_i),
        .timeout_hit_i   (w_timeout_hit),
        .pc_next_o       (pc_d),
        .redirect_o      (w_redirect),
        .misalign_o      (w_misalign),
        .timeout_o       (w_timeout),
        .target_o        (w_target)
    );

    // Next state, stall counter and captured bad address.
    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        bad_addr_d = w_misalign ? w_target : bad_addr_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (w_redirect) begin
                    state_d = ST_REDIRECT;
                end else if (stall_i) begin
                    state_d = ST_STALL;
                    cnt_d   = CNT_W'(1);
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STALL: begin
                if (w_redirect) begin
                    state_d = ST_REDIRECT;
                end else if (stall_i) begin
                    state_d = ST_STALL;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_REDIRECT: begin
                state_d = w_redirect ? ST_REDIRECT : ST_RUN;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State, PC, counter and pulse-flag registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            cnt_q      <= '0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
            bad_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            misalign_q <= w_misalign;
            timeout_q  <= w_timeout;
            bad_addr_q <= bad_addr_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_next_o  = pc_d;
    assign pc_valid_o = (state_q == ST_RUN) || (state_q == ST_STALL);
    assign flush_o    = (state_q == ST_REDIRECT);
    assign misalign_o = misalign_q;
    assign timeout_o  = timeout_q;
    assign bad_addr_o = bad_addr_q;
    assign state_o    = state_q;

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Directed self-checking bench for pc_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic        CLK;
    logic        RST;
    logic        stall_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        jump_i;
    logic [31:0] jump_target_i;
    logic        trap_i;
    logic [31:0] pc_o;
    logic [31:0] pc_next_o;
    logic        pc_valid_o;
    logic        flush_o;
    logic        misalign_o;
    logic        timeout_o;
    logic [31:0] bad_addr_o;
    logic [1:0]  state_o;

    int n_cmp;
    int n_bad;

    pc_sequencer u_dut (
        .CLK             (CLK),
        .RST             (RST),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .trap_i          (trap_i),
        .pc_o            (pc_o),
        .pc_next_o       (pc_next_o),
        .pc_valid_o      (pc_valid_o),
        .flush_o         (flush_o),
        .misalign_o      (misalign_o),
        .timeout_o       (timeout_o),
        .bad_addr_o      (bad_addr_o),
        .state_o         (state_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle before sampling.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Check the main observable bundle in one call.
    task automatic chk_core(input string tag, input logic [31:0] pc, input logic valid,
                            input logic flush, input logic [1:0] st);
        chk({tag, ".pc"},    pc_o,              pc);
        chk({tag, ".valid"}, {31'd0, pc_valid_o}, {31'd0, valid});
        chk({tag, ".flush"}, {31'd0, flush_o},    {31'd0, flush});
        chk({tag, ".state"}, {30'd0, state_o},    {30'd0, st});
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        RST = 1'b1;
        stall_i = 1'b0; branch_taken_i = 1'b0; jump_i = 1'b0; trap_i = 1'b0;
        branch_target_i = 32'h0; jump_target_i = 32'h0;

        // 1: reset, BOOT, sequential fetch
        step(); step();
        chk_core("rst", 32'h0, 1'b0, 1'b0, 2'd0);
        chk("rst.misalign", {31'd0, misalign_o}, 32'd0);
        chk("rst.timeout",  {31'd0, timeout_o},  32'd0);
        chk("rst.bad",      bad_addr_o,          32'h0);
        RST = 1'b0;
        #1;
        chk_core("boot", 32'h0, 1'b0, 1'b0, 2'd0);
        step(); chk_core("run0", 32'h0, 1'b1, 1'b0, 2'd1);
        step(); chk_core("run4", 32'h4, 1'b1, 1'b0, 2'd1);
        step(); chk_core("run8", 32'h8, 1'b1, 1'b0, 2'd1);

        // 2: taken branch from 0x8 to 0x40
        branch_taken_i = 1'b1; branch_target_i = 32'h40;
        #1; chk("br.next", pc_next_o, 32'h40);
        step(); branch_taken_i = 1'b0;
        chk_core("br.bubble", 32'h40, 1'b0, 1'b1, 2'd3);
        chk("br.bubble_next", pc_next_o, 32'h40);
        step(); chk_core("br.fetch", 32'h40, 1'b1, 1'b0, 2'd1);
        step(); chk_core("br.seq", 32'h44, 1'b1, 1'b0, 2'd1);

        // 3: misaligned jump target
        jump_i = 1'b1; jump_target_i = 32'h42;
        #1; chk("mis.next", pc_next_o, 32'h100);
        step(); jump_i = 1'b0;
        chk_core("mis.bubble", 32'h100, 1'b0, 1'b1, 2'd3);
        chk("mis.pulse", {31'd0, misalign_o}, 32'd1);
        chk("mis.bad",   bad_addr_o,          32'h42);
        step(); chk_core("mis.fetch", 32'h100, 1'b1, 1'b0, 2'd1);
        chk("mis.pulse_off", {31'd0, misalign_o}, 32'd0);
        chk("mis.bad_hold",  bad_addr_o,          32'h42);

        // 4a: jump to 0x20, then a 3-cycle stall
        jump_i = 1'b1; jump_target_i = 32'h20;
        step(); jump_i = 1'b0;
        step(); chk_core("st.start", 32'h20, 1'b1, 1'b0, 2'd1);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); chk_core("st.hold", 32'h20, 1'b1, 1'b0, 2'd2);
        end
        stall_i = 1'b0;
        step(); chk_core("st.resume", 32'h24, 1'b1, 1'b0, 2'd1);

        // 4b: 16 consecutive stall cycles fire the timeout
        stall_i = 1'b1;
        for (int i = 0; i < 15; i++) step();
        chk_core("to.pre", 32'h24, 1'b1, 1'b0, 2'd2);
        chk("to.pre_pulse", {31'd0, timeout_o}, 32'd0);
        step(); stall_i = 1'b0;
        chk_core("to.fire", 32'h100, 1'b0, 1'b1, 2'd3);
        chk("to.pulse", {31'd0, timeout_o}, 32'd1);
        step(); chk_core("to.fetch", 32'h100, 1'b1, 1'b0, 2'd1);
        chk("to.pulse_off", {31'd0, timeout_o}, 32'd0);
        step(); chk_core("to.seq", 32'h104, 1'b1, 1'b0, 2'd1);

        // 5: everything at once from 0x104, trap wins; trap again in bubble
        trap_i = 1'b1; jump_i = 1'b1; jump_target_i = 32'h40;
        branch_taken_i = 1'b1; branch_target_i = 32'h80; stall_i = 1'b1;
        #1; chk("all.next", pc_next_o, 32'h100);
        step(); jump_i = 1'b0; branch_taken_i = 1'b0; stall_i = 1'b0;
        chk_core("all.bubble", 32'h100, 1'b0, 1'b1, 2'd3);
        chk("all.no_mis", {31'd0, misalign_o}, 32'd0);
        step(); trap_i = 1'b0;
        chk_core("trap.bubble2", 32'h100, 1'b0, 1'b1, 2'd3);
        step(); chk_core("trap.fetch", 32'h100, 1'b1, 1'b0, 2'd1);

        // 5b: jump during bubble is ignored
        jump_i = 1'b1; jump_target_i = 32'h200;
        step(); jump_target_i = 32'h300;
        #1; chk("ign.next", pc_next_o, 32'h200);
        step(); jump_i = 1'b0;
        chk_core("ign.fetch", 32'h200, 1'b1, 1'b0, 2'd1);

        // 6: address wrap and asynchronous reset
        jump_i = 1'b1; jump_target_i = 32'hFFFF_FFFC;
        step(); jump_i = 1'b0;
        step(); chk_core("wrap.top", 32'hFFFF_FFFC, 1'b1, 1'b0, 2'd1);
        chk("wrap.next", pc_next_o, 32'h0);
        step(); chk_core("wrap.zero", 32'h0, 1'b1, 1'b0, 2'd1);
        step(); chk("wrap.four", pc_o, 32'h4);
        #2; RST = 1'b1;
        #1; chk_core("arst", 32'h0, 1'b0, 1'b0, 2'd0);
        chk("arst.bad", bad_addr_o, 32'h0);
        step(); RST = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pc_sequencer
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Controller that sequences the program counter register. Each cycle it picks the next fetch address from: sequential (PC+4), branch target, jump target, trap vector, or hold (stall). It inserts a one-cycle fetch bubble with a flush pulse on every redirect. It traps misaligned targets and stalls that last too long. It sits between the hazard/branch units and the instruction-memory address port.

Parameters:
XLEN, 32, address width
RESET_VECTOR, 32'h0000_0000, first fetch address after reset
TRAP_VECTOR, 32'h0000_0100, redirect address for trap, misalign or timeout
STALL_TIMEOUT, 16, consecutive stall cycles before timeout trap; 0 disables the timeout
CNT_W, 8, stall counter width; must satisfy STALL_TIMEOUT < 2^CNT_W

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-high reset
stall_i  input  1  hold current PC
branch_taken_i  input  1  conditional branch resolved taken
branch_target_i  input  XLEN  branch target
jump_i  input  1  JAL/JALR redirect
jump_target_i  input  XLEN  jump target
trap_i  input  1  external trap request
pc_o  output  XLEN  current fetch address (registered)
pc_next_o  output  XLEN  address pc_o takes at the next edge (combinational)
pc_valid_o  output  1  pc_o is a valid fetch
flush_o  output  1  kill younger in-flight instructions
misalign_o  output  1  one-cycle pulse: redirect target was not 4-byte aligned
timeout_o  output  1  one-cycle pulse: stall timeout fired
bad_addr_o  output  XLEN  last misaligned target captured
state_o  output  2  FSM state, for debug

Behaviour:
- Clocking and reset: one clock (CLK); RST is asynchronous and active-high.
- Reset values while RST is high: state=BOOT, pc_o=RESET_VECTOR, pc_valid_o=0, flush_o=0, misalign_o=0, timeout_o=0, bad_addr_o=0, stall count=0.
- Reset asserted mid-operation returns every output to these values immediately, without waiting for a clock edge.
- FSM states, with encoding from the package: BOOT=0, RUN=1, STALL=2, REDIRECT=3.
- BOOT:
  - Lasts exactly one cycle; all inputs ignored.
  - pc_valid_o=0. Next state RUN with pc_o unchanged, so the first valid fetch is RESET_VECTOR.
- RUN:
  - pc_valid_o=1.
  - Next-PC priority: trap_i > jump_i > branch_taken_i > stall_i > sequential.
  - trap_i: pc<=TRAP_VECTOR, go to REDIRECT.
  - jump_i or branch_taken_i with target[1:0]==0: pc<=target, go to REDIRECT.
  - Misaligned target: pc<=TRAP_VECTOR, bad_addr_o<=target, misalign_o=1 for one cycle, go to REDIRECT.
  - stall_i only: pc held, go to STALL, count<=1.
  - Otherwise: pc<=pc+4, modulo 2^XLEN (0xFFFF_FFFC -> 0x0000_0000).
- STALL:
  - pc_valid_o=1 and pc held (fetch re-issued).
  - Redirects keep RUN priority and semantics; a redirect overrides stall and clears count.
  - stall_i=0: pc<=pc+4, go to RUN, count<=0.
  - stall_i=1 and count==STALL_TIMEOUT-1 (STALL_TIMEOUT!=0): pc<=TRAP_VECTOR, timeout_o=1 for one cycle, go to REDIRECT.
  - Otherwise count increments.
- REDIRECT:
  - Exactly one bubble cycle: pc_valid_o=0, flush_o=1. pc_o already holds the target.
  - trap_i is still honoured: pc<=TRAP_VECTOR and stay in REDIRECT for another bubble.
  - jump, branch and stall inputs are ignored (their instructions are being flushed).
  - Otherwise go to RUN; pc is not incremented in this cycle.
- Pulse timing: misalign_o and timeout_o are registered and assert in the same cycle flush_o first asserts.
- pc_next_o always equals the value pc_o will hold after the next edge, given the current inputs.
- Latency: a redirect request in cycle N gives pc_o=target and flush_o=1 in cycle N+1, and the first valid fetch of the target in cycle N+2.

Decomposition:
- Package pc_seq_pkg holds:
  - the state enum typedef;
  - XLEN;
  - INSTR_BYTES=4;
  - default RESET_VECTOR and TRAP_VECTOR constants;
  - an is_aligned function.
- One natural combinational sub-module, pc_next_mux: priority select plus alignment check, producing pc_next and the misalign flag.
- The FSM, PC register, stall counter and pulse flags stay in pc_sequencer.

Test Plan:
1. RST high 2 cycles then low, no requests -> pc_o 0x0 with pc_valid_o=0 (BOOT), then 0x0 valid, 0x4, 0x8, 0xC on consecutive cycles.
2. In RUN at pc=0x8, branch_taken_i=1 with target 0x40 -> next cycle pc_o=0x40, flush_o=1, pc_valid_o=0; following cycle valid 0x40, then 0x44.
3. jump_i=1, target 0x42 -> pc_o=0x100, misalign_o=1, bad_addr_o=0x42, flush_o=1 in the same cycle.
4. stall_i held 3 cycles at pc=0x20 -> pc_o stays 0x20, valid, for 3 cycles, then 0x24. stall_i held 16 cycles -> timeout_o=1, pc_o=0x100.
5. trap_i, jump_i, branch_taken_i and stall_i all asserted together -> pc_o=0x100 (trap wins). trap_i again during REDIRECT -> second bubble, pc_o=0x100.
6. Preload pc=0xFFFF_FFFC via jump, then free-run -> 0x0. Assert RST asynchronously between edges -> pc_o=0x0 and pc_valid_o=0 immediately.
